// File: rtl/enemy_spawn_sched.sv
// enemy_spawn_sched
//   Frame-based spawn scheduler for three enemy classes. Each class counts
//   frames (v_sync rising edges) up to a level-scaled period and then raises
//   a pending request. A round-robin arbiter grants one pending class that
//   has a free slot. It emits a one-cycle one-hot trigger with the slot index
//   and a spawn x position. Two guard cycles follow each grant, so the
//   granted slot's free flag can drop before the next arbitration.
//
// Ports
//   clk_vga      pixel clock
//   rst          asynchronous active-high reset
//   en_i         game running; low freezes frame counting and new grants
//   v_sync_i     vertical sync, rising edge = one frame
//   level_i      difficulty 0..3, divides the base periods by 2^level
//   rand_i       pseudo-random x seed
//   free1/2/3_i  per-slot free flags of each class
//   trig_o       one-hot spawn pulse (bit k-1 = class k)
//   trig_idx_o   lowest free slot index of the granted class
//   trig_x_o     spawn x, folded into [0, XMAXk)
module enemy_spawn_sched #(
  parameter int         N1    = 8,
  parameter int         N2    = 4,
  parameter int         N3    = 2,
  parameter logic [7:0] PER1  = 8'd30,
  parameter logic [7:0] PER2  = 8'd90,
  parameter logic [7:0] PER3  = 8'd240,
  parameter logic [8:0] XMAX1 = 9'd440,
  parameter logic [8:0] XMAX2 = 9'd410,
  parameter logic [8:0] XMAX3 = 9'd310
) (
  input  logic          clk_vga,
  input  logic          rst,
  input  logic          en_i,
  input  logic          v_sync_i,
  input  logic [1:0]    level_i,
  input  logic [8:0]    rand_i,
  input  logic [N1-1:0] free1_i,
  input  logic [N2-1:0] free2_i,
  input  logic [N3-1:0] free3_i,
  output logic [2:0]    trig_o,
  output logic [2:0]    trig_idx_o,
  output logic [8:0]    trig_x_o
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GUARD1, S_GUARD2} state_t;

  localparam logic [2:0][7:0] PER  = {PER3, PER2, PER1};
  localparam logic [2:0][8:0] XMAX = {XMAX3, XMAX2, XMAX1};

  state_t          state_q, state_d;
  logic            vs_q, vs_d;
  logic [2:0][7:0] cnt_q, cnt_d;
  logic [2:0]      pend_q, pend_d;
  logic [1:0]      last_q, last_d;
  logic [2:0]      trig_q, trig_d;
  logic [2:0]      idx_q, idx_d;
  logic [8:0]      x_q, x_d;

  logic            tick;
  logic [2:0][7:0] free_pad;
  logic [2:0]      any_free;
  logic [2:0][2:0] low_idx;
  logic [2:0]      elig;
  logic [1:0]      win;
  logic            found;
  logic            grant;
  logic [1:0]      cand;
  logic [7:0]      per;
  logic            fire;

  // Free vectors widened to a common 8-bit lane; slot index is 3 bits.
  always_comb begin
    free_pad = '0;
    free_pad[0][N1-1:0] = free1_i;
    free_pad[1][N2-1:0] = free2_i;
    free_pad[2][N3-1:0] = free3_i;
    for (int k = 0; k < 3; k++) begin
      any_free[k] = |free_pad[k];
      low_idx[k]  = '0;
      // Scan downward so the lowest set bit is the last one written.
      for (int i = 7; i >= 0; i--)
        if (free_pad[k][i]) low_idx[k] = 3'(i);
    end
  end

  assign tick = v_sync_i & ~vs_q & en_i;
  assign elig = pend_q & any_free;

  // Round-robin search starting with the class after the last winner.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    cand  = '0;
    for (int o = 1; o <= 3; o++) begin
      cand = 2'((int'(last_q) + o) % 3);
      if (!found && elig[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  assign grant = (state_q == S_IDLE) && en_i && found;

  // Frame counters and pending flags.
  always_comb begin
    vs_d   = v_sync_i;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    per    = '0;
    fire   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      per = PER[k] >> level_i;
      if (per == 8'd0) per = 8'd1;
      fire = 1'b0;
      if (tick) begin
        // A class being granted this cycle counts as unblocked, so the
        // counter keeps running from the tick that coincides with its grant.
        if (pend_q[k] && !(grant && win == 2'(k))) begin
          cnt_d[k] = '0;
        end else if (({1'b0, cnt_q[k]} + 9'd1) >= {1'b0, per}) begin
          cnt_d[k] = '0;
          fire     = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 8'd1;
        end
      end
      // Grant clear wins over a same-cycle set.
      pend_d[k] = (pend_q[k] | fire) & ~(grant && win == 2'(k));
    end
  end

  // Grant sequencer; trigger outputs are registered so they line up with GRANT.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    trig_d  = '0;
    idx_d   = idx_q;
    x_d     = x_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_GRANT;
          last_d  = win;
          trig_d  = 3'b001 << win;
          idx_d   = low_idx[win];
          if (rand_i < XMAX[win]) x_d = rand_i;
          else                    x_d = rand_i - XMAX[win];
        end
      end
      S_GRANT:  state_d = S_GUARD1;
      S_GUARD1: state_d = S_GUARD2;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= '0;
      last_q  <= 2'd2;
      trig_q  <= '0;
      idx_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      trig_q  <= trig_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
    end
  end

  assign trig_o     = trig_q;
  assign trig_idx_o = idx_q;
  assign trig_x_o   = x_q;

endmodule
